// File: rtl/cla_addsub_pipe.sv
// Pipelined carry-lookahead adder/subtractor with a sideband tag and valid/ready on both sides.
// Each register stage finishes one WIDTH/SEGS-bit segment; the last register drives the outputs.
module cla_addsub_pipe #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned SEGS  = 2,
  parameter int unsigned TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_sub,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf,
  output logic             out_zero,
  output logic [TAG_W-1:0] out_tag
);

  localparam int unsigned SW = WIDTH / SEGS;
  localparam int unsigned NG = SW / 4;

  if (WIDTH < 4 || (WIDTH % 4) != 0 || SEGS < 1 || ((WIDTH / 4) % SEGS) != 0 || TAG_W < 1)
  begin : g_param_check
    $fatal(1, "cla_addsub_pipe: illegal WIDTH/SEGS/TAG_W combination");
  end

  // Two-level lookahead over one segment; returns {carry out, carry into MSB, sum}.
  function automatic logic [SW+1:0] seg_add(input logic [SW-1:0] a, input logic [SW-1:0] b,
                                            input logic cin);
    logic [SW-1:0] g, p, c;
    logic [NG-1:0] gg, gp;
    logic [NG:0]   gc;
    logic          t, acc;
    g = a & b;
    p = a ^ b;
    for (int j = 0; j < int'(NG); j++) begin
      gg[j] = 1'b0;
      gp[j] = 1'b1;
      for (int i = 0; i < 4; i++) begin
        t = g[4*j+i];
        for (int m = i + 1; m < 4; m++) t = t & p[4*j+m];
        gg[j] = gg[j] | t;
        gp[j] = gp[j] & p[4*j+i];
      end
    end
    for (int j = 0; j <= int'(NG); j++) begin
      acc = cin;
      for (int m = 0; m < j; m++) acc = acc & gp[m];
      for (int i = 0; i < j; i++) begin
        t = gg[i];
        for (int m = i + 1; m < j; m++) t = t & gp[m];
        acc = acc | t;
      end
      gc[j] = acc;
    end
    for (int j = 0; j < int'(NG); j++) begin
      for (int i = 0; i < 4; i++) begin
        acc = gc[j];
        for (int m = 0; m < i; m++) acc = acc & p[4*j+m];
        for (int k = 0; k < i; k++) begin
          t = g[4*j+k];
          for (int m = k + 1; m < i; m++) t = t & p[4*j+m];
          acc = acc | t;
        end
        c[4*j+i] = acc;
      end
    end
    return {gc[NG], c[SW-1], p ^ c};
  endfunction

  logic [SEGS-1:0]  vld_q, vld_d, adv, load;
  logic [SEGS-1:0]  c_q, c_d;
  logic [WIDTH-1:0] sum_q [SEGS];
  logic [WIDTH-1:0] sum_d [SEGS];
  logic [WIDTH-1:0] a_q   [SEGS];
  logic [WIDTH-1:0] a_d   [SEGS];
  logic [WIDTH-1:0] b_q   [SEGS];
  logic [WIDTH-1:0] b_d   [SEGS];
  logic [TAG_W-1:0] tag_q [SEGS];
  logic [TAG_W-1:0] tag_d [SEGS];
  logic             ovf_q, ovf_d, zero_q, zero_d;

  logic [WIDTH-1:0] src_a   [SEGS];
  logic [WIDTH-1:0] src_b   [SEGS];
  logic [WIDTH-1:0] src_sum [SEGS];
  logic [TAG_W-1:0] src_tag [SEGS];
  logic [SEGS-1:0]  src_c;

  // Stall chain: a stage can take new data when it is empty or its content moves on.
  always_comb begin : p_handshake
    logic rdy;
    rdy = out_ready;
    adv = '0;
    for (int s = int'(SEGS) - 1; s >= 0; s--) begin
      adv[s] = vld_q[s] & rdy;
      rdy    = ~vld_q[s] | adv[s];
    end
    in_ready = rdy;
    load     = {adv[SEGS-1:0], in_valid & rdy} >> 0;
  end

  always_comb begin : p_src
    src_a[0]   = in_a;
    src_b[0]   = in_sub ? ~in_b : in_b;
    src_c[0]   = in_sub;
    src_sum[0] = '0;
    src_tag[0] = in_tag;
    for (int s = 1; s < int'(SEGS); s++) begin
      src_a[s]   = a_q[s-1];
      src_b[s]   = b_q[s-1];
      src_c[s]   = c_q[s-1];
      src_sum[s] = sum_q[s-1];
      src_tag[s] = tag_q[s-1];
    end
  end

  always_comb begin : p_stage
    logic [SW+1:0]    res;
    logic [WIDTH-1:0] sum_new;
    ovf_d  = ovf_q;
    zero_d = zero_q;
    for (int s = 0; s < int'(SEGS); s++) begin
      res                  = seg_add(src_a[s][s*SW +: SW], src_b[s][s*SW +: SW], src_c[s]);
      sum_new              = src_sum[s];
      sum_new[s*SW +: SW]  = res[SW-1:0];
      vld_d[s] = load[s] | (vld_q[s] & ~adv[s]);
      sum_d[s] = load[s] ? sum_new    : sum_q[s];
      a_d[s]   = load[s] ? src_a[s]   : a_q[s];
      b_d[s]   = load[s] ? src_b[s]   : b_q[s];
      tag_d[s] = load[s] ? src_tag[s] : tag_q[s];
      c_d[s]   = load[s] ? res[SW+1]  : c_q[s];
      if (s == int'(SEGS) - 1 && load[s]) begin
        ovf_d  = res[SW+1] ^ res[SW];
        zero_d = ~|sum_new;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q  <= '0;
      c_q    <= '0;
      ovf_q  <= 1'b0;
      zero_q <= 1'b0;
      for (int s = 0; s < int'(SEGS); s++) begin
        sum_q[s] <= '0;
        a_q[s]   <= '0;
        b_q[s]   <= '0;
        tag_q[s] <= '0;
      end
    end else begin
      vld_q  <= vld_d;
      c_q    <= c_d;
      ovf_q  <= ovf_d;
      zero_q <= zero_d;
      for (int s = 0; s < int'(SEGS); s++) begin
        sum_q[s] <= sum_d[s];
        a_q[s]   <= a_d[s];
        b_q[s]   <= b_d[s];
        tag_q[s] <= tag_d[s];
      end
    end
  end

  assign out_valid = vld_q[SEGS-1];
  assign out_sum   = sum_q[SEGS-1];
  assign out_cout  = c_q[SEGS-1];
  assign out_ovf   = ovf_q;
  assign out_zero  = zero_q;
  assign out_tag   = tag_q[SEGS-1];

endmodule

// File: tb/tb_cla_addsub_pipe.sv
// Directed bench for cla_addsub_pipe at WIDTH=16, SEGS=2, TAG_W=4.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_cla_addsub_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, in_sub, out_valid, out_ready;
  logic [15:0] in_a, in_b, out_sum;
  logic        out_cout, out_ovf, out_zero;
  logic [3:0]  in_tag, out_tag;

  int total  = 0;
  int passed = 0;

  always #5 clk = ~clk;

  cla_addsub_pipe #(.WIDTH(16), .SEGS(2), .TAG_W(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_a     (in_a),
    .in_b     (in_b),
    .in_sub   (in_sub),
    .in_tag   (in_tag),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_sum  (out_sum),
    .out_cout (out_cout),
    .out_ovf  (out_ovf),
    .out_zero (out_zero),
    .out_tag  (out_tag)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
  endtask

  task automatic check_res(input string tag, input logic [15:0] sum, input logic cout,
                           input logic ovf, input logic zero, input logic [3:0] t);
    check({tag, ".valid"}, 32'(out_valid), 32'd1);
    check({tag, ".sum"},   32'(out_sum),   32'(sum));
    check({tag, ".cout"},  32'(out_cout),  32'(cout));
    check({tag, ".ovf"},   32'(out_ovf),   32'(ovf));
    check({tag, ".zero"},  32'(out_zero),  32'(zero));
    check({tag, ".tag"},   32'(out_tag),   32'(t));
  endtask

  task automatic drive(input logic v, input logic [15:0] a, input logic [15:0] b,
                       input logic sub, input logic [3:0] t);
    in_valid = v;
    in_a     = a;
    in_b     = b;
    in_sub   = sub;
    in_tag   = t;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, observed timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    out_ready = 1'b1;
    drive(1'b0, 16'h0, 16'h0, 1'b0, 4'h0);
    repeat (2) @(negedge clk);
    check("rst.valid", 32'(out_valid), 32'd0);
    check("rst.sum",   32'(out_sum),   32'd0);
    check("rst.flags", 32'({out_cout, out_ovf, out_zero}), 32'd0);
    check("rst.tag",   32'(out_tag),   32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst.in_ready", 32'(in_ready), 32'd1);

    // Carry out of every bit, result wraps to zero.
    drive(1'b1, 16'hFFFF, 16'h0001, 1'b0, 4'd3);
    #1 check("t1.in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    drive(1'b0, 16'h0, 16'h0, 1'b0, 4'd0);
    check("t1.lat1", 32'(out_valid), 32'd0);
    @(negedge clk);
    check_res("t1", 16'h0000, 1'b1, 1'b0, 1'b1, 4'd3);
    @(negedge clk);
    check("t1.drain", 32'(out_valid), 32'd0);

    // Subtraction: signed overflow, then a borrow.
    drive(1'b1, 16'h8000, 16'h0001, 1'b1, 4'd5);
    @(negedge clk);
    drive(1'b1, 16'h0003, 16'h0005, 1'b1, 4'd6);
    @(negedge clk);
    drive(1'b0, 16'h0, 16'h0, 1'b0, 4'd0);
    check_res("t2a", 16'h7FFF, 1'b1, 1'b1, 1'b0, 4'd5);
    @(negedge clk);
    check_res("t2b", 16'hFFFE, 1'b0, 1'b0, 1'b0, 4'd6);
    @(negedge clk);

    // Four back-to-back ops; results 2 cycles later, in order.
    for (int c = 0; c < 7; c++) begin
      if (c >= 2 && c < 6) begin
        check_res("t3", 16'((c - 2) * 16'h1111 + 16'h0101), 1'b0, 1'b0, 1'b0, 4'(c - 2));
      end else begin
        check("t3.idle", 32'(out_valid), 32'd0);
      end
      if (c < 4) begin
        drive(1'b1, 16'(c * 16'h1111), 16'h0101, 1'b0, 4'(c));
        #1 check("t3.in_ready", 32'(in_ready), 32'd1);
      end else begin
        drive(1'b0, 16'h0, 16'h0, 1'b0, 4'd0);
      end
      @(negedge clk);
    end

    // Backpressure: sink stalls 5 cycles while the source keeps offering.
    out_ready = 1'b0;
    drive(1'b1, 16'h1234, 16'h1111, 1'b0, 4'd8);
    #1 check("t4.acc0", 32'(in_ready), 32'd1);
    @(negedge clk);
    drive(1'b1, 16'h00FF, 16'h0001, 1'b0, 4'd9);
    #1 check("t4.acc1", 32'(in_ready), 32'd1);
    @(negedge clk);
    drive(1'b1, 16'h0010, 16'h0010, 1'b1, 4'd10);
    for (int c = 0; c < 3; c++) begin
      #1 check("t4.full", 32'(in_ready), 32'd0);
      check_res("t4.hold", 16'h2345, 1'b0, 1'b0, 1'b0, 4'd8);
      @(negedge clk);
    end
    out_ready = 1'b1;
    // Full pipe: accept and emit on the same edge.
    #1 check("t4.release", 32'(in_ready), 32'd1);
    check_res("t4.r0", 16'h2345, 1'b0, 1'b0, 1'b0, 4'd8);
    @(negedge clk);
    drive(1'b0, 16'h0, 16'h0, 1'b0, 4'd0);
    check_res("t4.r1", 16'h0100, 1'b0, 1'b0, 1'b0, 4'd9);
    @(negedge clk);
    check_res("t4.r2", 16'h0000, 1'b1, 1'b0, 1'b1, 4'd10);
    @(negedge clk);
    check("t4.empty", 32'(out_valid), 32'd0);

    // Asynchronous reset with two ops in flight.
    drive(1'b1, 16'h7FFF, 16'h0001, 1'b0, 4'd12);
    @(negedge clk);
    drive(1'b1, 16'h4321, 16'h1000, 1'b0, 4'd13);
    @(negedge clk);
    drive(1'b0, 16'h0, 16'h0, 1'b0, 4'd0);
    check_res("t5.pre", 16'h8000, 1'b0, 1'b1, 1'b0, 4'd12);
    #2 rst_n = 1'b0;
    #1 check("t5.valid", 32'(out_valid), 32'd0);
    check("t5.sum",   32'(out_sum), 32'd0);
    check("t5.flags", 32'({out_cout, out_ovf, out_zero}), 32'd0);
    check("t5.tag",   32'(out_tag), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 check("t5.in_ready", 32'(in_ready), 32'd1);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("t5.no_stale", 32'(out_valid), 32'd0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
